// File: rtl/seq_pkg.sv
// Shared types and widths for the serial pattern generator.
package seq_pkg;

   localparam int REPS_W = 4;
   localparam int GAP_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/seq_generator_if.sv
// Request/status bundle for seq_generator, plus debug visibility of FSM state.
// Optional abort input is present only when SEQ_GEN_ABORT_EN is defined.
interface seq_generator_if;

   // Handshake: start is a level sampled only while the generator is idle (busy=0);
   // reps is captured on the edge that accepts start. valid qualifies w per cycle.
   logic                           start;
   logic [seq_pkg::REPS_W-1:0]     reps;
`ifdef SEQ_GEN_ABORT_EN
   logic                           abort;
`endif
   logic                           w;
   logic                           valid;
   logic                           busy;
   logic                           done;
   seq_pkg::seq_state_t            state;
   logic [seq_pkg::REPS_W-1:0]     rem;
   logic [seq_pkg::GAP_W-1:0]      gap_cnt;

`ifdef SEQ_GEN_ABORT_EN
   modport master (output start, reps, abort,
                   input  w, valid, busy, done, state, rem, gap_cnt);
   modport slave  (input  start, reps, abort,
                   output w, valid, busy, done, state, rem, gap_cnt);
`else
   modport master (output start, reps,
                   input  w, valid, busy, done, state, rem, gap_cnt);
   modport slave  (input  start, reps,
                   output w, valid, busy, done, state, rem, gap_cnt);
`endif

endinterface

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
module seq_bit_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (!resetn)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec)
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/seq_generator.sv
// Repeats a fixed serial pattern MSB-first, reps times, with GAP idle cycles between.
// Build option: define SEQ_GEN_ABORT_EN to add an abort input (SEND/GAP -> IDLE).
module seq_generator
   import seq_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
   parameter int                 GAP     = 1
) (
   input  logic            Clock,
   input  logic            Resetn,
   seq_generator_if.slave  bus
);

   localparam int                 IDX_W   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
   localparam logic [IDX_W-1:0]   IDX_TOP = IDX_W'(PAT_LEN - 1);
   localparam logic [GAP_W-1:0]   GAP_TOP = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

   seq_state_t         state;
   logic [REPS_W-1:0]  rem;
   logic               w_q, valid_q, busy_q, done_q;

   logic [IDX_W-1:0]   idx_count, idx_prev;
   logic               idx_zero, idx_load, idx_dec;
   logic [GAP_W-1:0]   gap_count;
   logic               gap_zero, gap_load, gap_dec;
   logic               accept, last_bit, more, stop, abort_req;

`ifdef SEQ_GEN_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   assign idx_prev = idx_count - IDX_W'(1);

   // The parameter GAP shadows the state literal, so the state is named through the package.
   always_comb begin
      accept   = (state == IDLE) && bus.start && (bus.reps != '0);
      last_bit = (state == SEND) && idx_zero;
      more     = (rem > REPS_W'(1));
      stop     = abort_req && ((state == SEND) || (state == seq_pkg::GAP));
      idx_load = accept ||
                 (!stop && ((last_bit && more && (GAP == 0)) ||
                            ((state == seq_pkg::GAP) && gap_zero)));
      idx_dec  = !stop && (state == SEND) && !idx_zero;
      gap_load = !stop && last_bit && more && (GAP > 0);
      gap_dec  = !stop && (state == seq_pkg::GAP) && !gap_zero;
   end

   seq_bit_counter #(.W(IDX_W)) u_idx (
      .clk      (Clock),
      .resetn   (Resetn),
      .load     (idx_load),
      .load_val (IDX_TOP),
      .dec      (idx_dec),
      .count    (idx_count),
      .zero     (idx_zero)
   );

   seq_bit_counter #(.W(GAP_W)) u_gap (
      .clk      (Clock),
      .resetn   (Resetn),
      .load     (gap_load),
      .load_val (GAP_TOP),
      .dec      (gap_dec),
      .count    (gap_count),
      .zero     (gap_zero)
   );

   // Outputs are computed for the state being entered, so they line up with state.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state   <= IDLE;
         rem     <= '0;
         w_q     <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               w_q    <= 1'b0;
               done_q <= 1'b0;
               if (accept) begin
                  state   <= SEND;
                  rem     <= bus.reps;
                  w_q     <= PATTERN[IDX_TOP];
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            SEND: begin
               if (stop) begin
                  state   <= IDLE;
                  w_q     <= 1'b0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (!idx_zero) begin
                  w_q <= PATTERN[idx_prev];
               end else if (more) begin
                  rem <= rem - REPS_W'(1);
                  if (GAP > 0) begin
                     state   <= seq_pkg::GAP;
                     w_q     <= 1'b0;
                     valid_q <= 1'b0;
                  end else begin
                     w_q <= PATTERN[IDX_TOP];
                  end
               end else begin
                  state   <= DONE;
                  w_q     <= 1'b0;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            seq_pkg::GAP: begin
               if (stop) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (gap_zero) begin
                  state   <= SEND;
                  w_q     <= PATTERN[IDX_TOP];
                  valid_q <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               w_q     <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               w_q     <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.w       = w_q;
   assign bus.valid   = valid_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.state   = state;
   assign bus.rem     = rem;
   assign bus.gap_cnt = gap_count;

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: three parameterisations checked against a per-cycle stream model.
module tb_seq_generator;

   localparam int          NDUT = 3;
   localparam int          PL[NDUT]  = '{4, 4, 7};
   localparam int          GP[NDUT]  = '{1, 0, 3};
   localparam logic [15:0] PAT[NDUT] = '{16'h000D, 16'h000D, 16'h004D};

   logic Clock = 1'b0;
   logic Resetn;
   int   checks = 0;
   int   failures = 0;
   logic [3:0] exp_q[$];

   always #5 Clock = ~Clock;

   seq_generator_if bus0 ();
   seq_generator_if bus1 ();
   seq_generator_if bus2 ();

   seq_generator #(.PAT_LEN(4), .PATTERN(4'b1101), .GAP(1)) dut0 (
      .Clock(Clock), .Resetn(Resetn), .bus(bus0.slave));
   seq_generator #(.PAT_LEN(4), .PATTERN(4'b1101), .GAP(0)) dut1 (
      .Clock(Clock), .Resetn(Resetn), .bus(bus1.slave));
   seq_generator #(.PAT_LEN(7), .PATTERN(7'b1001101), .GAP(3)) dut2 (
      .Clock(Clock), .Resetn(Resetn), .bus(bus2.slave));

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input int sel, input logic s, input int r);
      case (sel)
         0: begin bus0.start = s; bus0.reps = 4'(r); end
         1: begin bus1.start = s; bus1.reps = 4'(r); end
         default: begin bus2.start = s; bus2.reps = 4'(r); end
      endcase
   endtask

   function automatic logic [3:0] get_out(input int sel);
      case (sel)
         0: return {bus0.w, bus0.valid, bus0.busy, bus0.done};
         1: return {bus1.w, bus1.valid, bus1.busy, bus1.done};
         default: return {bus2.w, bus2.valid, bus2.busy, bus2.done};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Entries are {w, valid, busy, done} per cycle, starting with the first cycle after acceptance.
   task automatic model_transfer(input int sel, input int r);
      logic [15:0] p;
      p = PAT[sel];
      for (int k = 0; k < r; k++) begin
         for (int b = PL[sel] - 1; b >= 0; b--)
            exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
         if (k < r - 1)
            for (int g = 0; g < GP[sel]; g++)
               exp_q.push_back(4'b0010);
      end
      if (r > 0)
         exp_q.push_back(4'b0011);
   endtask

   task automatic run_transfer(input int sel, input int r, input int exp_busy, input bit poke);
      logic [3:0] e, a;
      int nb, cyc;
      drive(sel, 1'b1, r);
      tick();
      drive(sel, 1'b0, 0);
      exp_q.delete();
      model_transfer(sel, r);
      repeat ((r == 0) ? 10 : 3) exp_q.push_back(4'b0000);
      nb = 0;
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = get_out(sel);
         check($sformatf("sel%0d reps%0d cyc%0d", sel, r, cyc), 32'(a), 32'(e));
         if (a[1]) nb++;
         if (poke && r > 0 && cyc == 2) drive(sel, 1'b1, 15);
         if (poke && r > 0 && cyc == 3) drive(sel, 1'b0, 0);
         tick();
         cyc++;
      end
      check($sformatf("sel%0d reps%0d busy_cycles", sel, r), 32'(nb), 32'(exp_busy));
   endtask

   typedef struct {
      int sel;
      int reps;
      int exp_busy;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{0, 1, 5};
      vecs[1] = '{0, 3, 15};
      vecs[2] = '{1, 2, 9};
      vecs[3] = '{0, 0, 0};
      vecs[4] = '{2, 2, 18};
      vecs[5] = '{0, 15, 75};
      vecs[6] = '{1, 1, 5};

      Resetn = 1'b0;
      for (int s = 0; s < NDUT; s++) drive(s, 1'b0, 0);
`ifdef SEQ_GEN_ABORT_EN
      bus0.abort = 1'b0;
      bus1.abort = 1'b0;
      bus2.abort = 1'b0;
`endif
      tick();
      tick();
      for (int s = 0; s < NDUT; s++)
         check($sformatf("reset outputs sel%0d", s), 32'(get_out(s)), 32'h0);
      check("reset state", 32'(bus0.state), 32'(seq_pkg::IDLE));
      check("reset rem", 32'(bus0.rem), 32'h0);
      Resetn = 1'b1;
      tick();

      // ---- table-driven transfers ----
      for (int i = 0; i < 7; i++)
         run_transfer(vecs[i].sel, vecs[i].reps, vecs[i].exp_busy, 1'b0);

      // ---- start during busy is ignored ----
      run_transfer(0, 3, 15, 1'b1);

      // ---- reset during the second bit, with start also high ----
      drive(0, 1'b1, 2);
      tick();
      drive(0, 1'b0, 0);
      check("midrst bit1", 32'(get_out(0)), 32'hE);
      tick();
      check("midrst bit2", 32'(get_out(0)), 32'hE);
      Resetn = 1'b0;
      drive(0, 1'b1, 1);
      tick();
      check("midrst outputs", 32'(get_out(0)), 32'h0);
      check("midrst rem", 32'(bus0.rem), 32'h0);
      Resetn = 1'b1;
      drive(0, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst quiet", 32'(get_out(0)), 32'h0);
      end
      run_transfer(0, 1, 5, 1'b0);

      // ---- held start: second transfer begins two cycles after DONE ----
      begin
         logic [3:0] e;
         int cyc;
         exp_q.delete();
         model_transfer(0, 1);
         exp_q.push_back(4'b0000);
         model_transfer(0, 1);
         repeat (3) exp_q.push_back(4'b0000);
         drive(0, 1'b1, 1);
         tick();
         cyc = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("held cyc%0d", cyc), 32'(get_out(0)), 32'(e));
            if (cyc == 6) drive(0, 1'b0, 0);
            tick();
            cyc++;
         end
      end

`ifdef SEQ_GEN_ABORT_EN
      // ---- abort in GAP: idle next cycle, no done ----
      drive(0, 1'b1, 3);
      tick();
      drive(0, 1'b0, 0);
      repeat (4) tick();
      check("abort in gap", 32'(get_out(0)), 32'h2);
      bus0.abort = 1'b1;
      tick();
      bus0.abort = 1'b0;
      check("abort idle", 32'(get_out(0)), 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort quiet", 32'(get_out(0)), 32'h0);
      end
`endif

      // ---- randomized transfers ----
      for (int n = 0; n < 24; n++) begin
         int sel, r, eb;
         bit poke;
         sel  = int'($urandom_range(0, NDUT - 1));
         r    = int'($urandom_range(0, 15));
         poke = 1'($urandom_range(0, 1));
         eb   = (r == 0) ? 0 : r * PL[sel] + (r - 1) * GP[sel] + 1;
         run_transfer(sel, r, eb, poke);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
